// File: rtl/lane_pkg.sv
// Shared types and constants for the lane round controller.
package lane_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      EXEC  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } ctrl_state_t;

   localparam logic [1:0] ADDR_SEL_RD   = 2'b00;
   localparam logic [1:0] ADDR_SEL_WR   = 2'b01;
   localparam logic [1:0] ADDR_SEL_HOST = 2'b10;

   localparam logic [1:0] OP_FIXED = 2'b11;

   // Width of the round index output; covers up to 16 rounds.
   localparam int ROUND_W = 4;

   // Operation select for a word: fixed op in op_mode 1, otherwise round mod 4.
   function automatic logic [1:0] op_for_round(input logic fixed_op,
                                               input logic [1:0] round_lsb);
      return fixed_op ? OP_FIXED : round_lsb;
   endfunction

endpackage

// File: rtl/lane_word_counter.sv
// Word/round counter pair for the lane round controller.
// adv steps to the next word, rolling into the next round after the last
// word; at the last word of the last round it holds so the FSM can finish.
module lane_word_counter
   import lane_pkg::*;
#(
   parameter int NUM_WORDS  = 25,
   parameter int ADDR_W     = 5,
   parameter int NUM_ROUNDS = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               adv,
   output logic [ADDR_W-1:0]  word_cnt,
   output logic [ROUND_W-1:0] round_idx,
   output logic               last_word,
   output logic               last_round
);

   localparam logic [ADDR_W-1:0]  LAST_WORD  = ADDR_W'(NUM_WORDS - 1);
   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

   // Terminal-count flags decoded from the counter registers.
   always_comb begin
      last_word  = (word_cnt == LAST_WORD);
      last_round = (round_idx == LAST_ROUND);
   end

   // Counter registers: explicit clear only, no overflow wrap.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         word_cnt  <= '0;
         round_idx <= '0;
      end else if (adv) begin
         if (!last_word) begin
            word_cnt <= word_cnt + 1'b1;
         end else if (!last_round) begin
            word_cnt  <= '0;
            round_idx <= round_idx + 1'b1;
         end
      end
   end

endmodule

// File: rtl/lane_round_ctrl.sv
// Sequencing controller for the 25-word x 128-bit state memory datapath.
// Each word is read (READ), its selected operation result latched (EXEC)
// and written back (WRITE), for NUM_ROUNDS sweeps of all words.
// Optional feature macro: LANE_ROUND_CTRL_SKIP_EN adds input skip_word,
// which lets a word finish directly from READ without EXEC/WRITE.
// All outputs are decoded from registers only.
module lane_round_ctrl
   import lane_pkg::*;
#(
   parameter int NUM_WORDS  = 25,
   parameter int ADDR_W     = 5,
   parameter int NUM_ROUNDS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              op_mode,
`ifdef LANE_ROUND_CTRL_SKIP_EN
   input  logic              skip_word,
`endif
   output logic [ADDR_W-1:0] word_cnt,
   output logic [1:0]        addr_sel,
   output logic [1:0]        op_sel,
   output logic              mem_rd,
   output logic              ld_reg,
   output logic              mem_wr,
   output logic              busy,
   output logic              done,
   output logic [3:0]        round_idx
);

   ctrl_state_t  state;
   ctrl_state_t  next_state;
   logic         mode_q;
   logic         skip_now;
   logic         cnt_adv;
   logic         cnt_clr;
   logic         last_word;
   logic         last_round;
   logic         run_last;

   // Skip request only matters while the read for the word is in flight.
`ifdef LANE_ROUND_CTRL_SKIP_EN
   assign skip_now = (state == READ) && skip_word;
`else
   assign skip_now = 1'b0;
`endif

   // Counter advances at the end of each word; cleared when leaving DONE.
   assign cnt_adv  = (state == WRITE) || skip_now;
   assign cnt_clr  = (state == DONE);
   assign run_last = last_word && last_round;

   lane_word_counter #(
      .NUM_WORDS  (NUM_WORDS),
      .ADDR_W     (ADDR_W),
      .NUM_ROUNDS (NUM_ROUNDS)
   ) u_counter (
      .clk        (clk),
      .rst        (rst),
      .clr        (cnt_clr),
      .adv        (cnt_adv),
      .word_cnt   (word_cnt),
      .round_idx  (round_idx),
      .last_word  (last_word),
      .last_round (last_round)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Operation mode is captured when a run is accepted and held for the run.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q <= 1'b0;
      end else if ((state == IDLE) && start) begin
         mode_q <= op_mode;
      end
   end

   // Next-state logic; start is only looked at in IDLE.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (start) next_state = READ;
         end
         READ: begin
            if (skip_now) begin
               next_state = run_last ? DONE : READ;
            end else begin
               next_state = EXEC;
            end
         end
         EXEC: begin
            next_state = WRITE;
         end
         WRITE: begin
            next_state = run_last ? DONE : READ;
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Output decode from the state register; the host owns memory when idle.
   always_comb begin
      addr_sel = ADDR_SEL_HOST;
      op_sel   = 2'b00;
      mem_rd   = 1'b0;
      ld_reg   = 1'b0;
      mem_wr   = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state)
         READ: begin
            addr_sel = ADDR_SEL_RD;
            op_sel   = op_for_round(mode_q, round_idx[1:0]);
            mem_rd   = 1'b1;
            busy     = 1'b1;
         end
         EXEC: begin
            addr_sel = ADDR_SEL_RD;
            op_sel   = op_for_round(mode_q, round_idx[1:0]);
            ld_reg   = 1'b1;
            busy     = 1'b1;
         end
         WRITE: begin
            addr_sel = ADDR_SEL_WR;
            op_sel   = op_for_round(mode_q, round_idx[1:0]);
            mem_wr   = 1'b1;
            busy     = 1'b1;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
            addr_sel = ADDR_SEL_HOST;
         end
      endcase
   end

endmodule

// File: tb/tb_lane_round_ctrl.sv
// Directed bench for lane_round_ctrl (default parameters: 25 words, 4 rounds).
module tb_lane_round_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       op_mode;
`ifdef LANE_ROUND_CTRL_SKIP_EN
   logic       skip_word;
   bit         skip_mode;
`endif
   logic [4:0] word_cnt;
   logic [1:0] addr_sel;
   logic [1:0] op_sel;
   logic       mem_rd;
   logic       ld_reg;
   logic       mem_wr;
   logic       busy;
   logic       done;
   logic [3:0] round_idx;

   int tests  = 0;
   int failed = 0;

   lane_round_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op_mode   (op_mode),
`ifdef LANE_ROUND_CTRL_SKIP_EN
      .skip_word (skip_word),
`endif
      .word_cnt  (word_cnt),
      .addr_sel  (addr_sel),
      .op_sel    (op_sel),
      .mem_rd    (mem_rd),
      .ld_reg    (ld_reg),
      .mem_wr    (mem_wr),
      .busy      (busy),
      .done      (done),
      .round_idx (round_idx)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: observed no finish, expected finish before 1ms");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Starts a run from IDLE and follows it cycle by cycle against a word/round
   // model. Returns in the DONE cycle, or in the cycle after a reset at rst_at.
   task automatic run(input logic mode, input int plo, input int phi, input int rst_at,
                      output int done_cyc, output int rd_n, output int wr_n,
                      output int ex_n, output int op_bad, output int seq_bad,
                      output int last_ok, output int wr_at_rst);
      int c;
      int lw;
      int er;
      int eo;
      done_cyc = 0; rd_n = 0; wr_n = 0; ex_n = 0;
      op_bad = 0; seq_bad = 0; last_ok = 0; wr_at_rst = 0;
      lw = 0; er = 0;
      start   = 1'b1;
      op_mode = mode;
      tick();
      start   = 1'b0;
      op_mode = ~mode;
      c = 1;
      while (done_cyc == 0 && c <= 400) begin
         if (c == rst_at) begin
            wr_at_rst = int'(mem_wr);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            start = 1'b0;
            return;
         end
         if (done) begin
            done_cyc = c;
         end else begin
            if (busy !== 1'b1) seq_bad++;
            if (int'(mem_rd) + int'(ld_reg) + int'(mem_wr) != 1) seq_bad++;
            if (addr_sel !== (mem_wr ? 2'b01 : 2'b00)) seq_bad++;
            if (mem_rd) begin
               lw = rd_n % 25;
               er = rd_n / 25;
               rd_n++;
            end
            if (word_cnt !== lw[4:0] || round_idx !== er[3:0]) seq_bad++;
            eo = mode ? 3 : (er % 4);
            if (op_sel !== eo[1:0]) op_bad++;
            if (ld_reg) ex_n++;
            if (mem_wr) wr_n++;
            if (c == 300 && mem_wr && word_cnt == 5'd24 && round_idx == 4'd3) last_ok = 1;
            start = (c >= plo && c <= phi);
`ifdef LANE_ROUND_CTRL_SKIP_EN
            skip_word = skip_mode && !word_cnt[0];
`endif
            tick();
            c++;
         end
      end
   endtask

   initial begin
      int dc, rd, wr, ex, ob, sb, lo, war, extra;
      rst = 1'b1; start = 1'b0; op_mode = 1'b0;
`ifdef LANE_ROUND_CTRL_SKIP_EN
      skip_word = 1'b0; skip_mode = 1'b0;
`endif
      repeat (2) tick();
      rst = 1'b0;
      repeat (5) tick();

      // Idle after reset
      check("idle_mem_rd",   mem_rd,    0);
      check("idle_ld_reg",   ld_reg,    0);
      check("idle_mem_wr",   mem_wr,    0);
      check("idle_busy",     busy,      0);
      check("idle_done",     done,      0);
      check("idle_addr_sel", addr_sel,  2);
      check("idle_op_sel",   op_sel,    0);
      check("idle_word_cnt", word_cnt,  0);
      check("idle_round",    round_idx, 0);

      // Default run, op_mode 0
      run(1'b0, 0, -1, -1, dc, rd, wr, ex, ob, sb, lo, war);
      check("m0_done_cycle", dc, 301);
      check("m0_reads",      rd, 100);
      check("m0_writes",     wr, 100);
      check("m0_execs",      ex, 100);
      check("m0_op_bad",     ob, 0);
      check("m0_seq_bad",    sb, 0);
      check("m0_last_write_c300", lo, 1);
      check("done_busy",     busy,     0);
      check("done_addr_sel", addr_sel, 2);
      check("done_op_sel",   op_sel,   0);
      check("done_mem_wr",   mem_wr,   0);
      tick();
      check("post_done_pulse", done,      0);
      check("post_word_cnt",   word_cnt,  0);
      check("post_round",      round_idx, 0);

      // op_mode 1 run
      run(1'b1, 0, -1, -1, dc, rd, wr, ex, ob, sb, lo, war);
      check("m1_done_cycle", dc, 301);
      check("m1_execs",      ex, 100);
      check("m1_op_bad",     ob, 0);
      check("m1_seq_bad",    sb, 0);
      tick();

      // start pulsed during cycles 50..60 is ignored
      run(1'b0, 50, 60, -1, dc, rd, wr, ex, ob, sb, lo, war);
      check("pulse_done_cycle", dc, 301);
      check("pulse_writes",     wr, 100);
      check("pulse_seq_bad",    sb, 0);
      extra = 0;
      repeat (5) begin
         tick();
         if (done || busy) extra++;
      end
      check("pulse_no_second_run", extra, 0);

      // Reset in the WRITE cycle at 150
      run(1'b0, 0, -1, 150, dc, rd, wr, ex, ob, sb, lo, war);
      check("rst_was_write", war, 1);
      check("rst_no_done",   dc,  0);
      check("rst_mem_wr",    mem_wr,    0);
      check("rst_busy",      busy,      0);
      check("rst_addr_sel",  addr_sel,  2);
      check("rst_word_cnt",  word_cnt,  0);
      check("rst_round",     round_idx, 0);
      extra = 0;
      repeat (3) begin
         tick();
         if (mem_wr || busy) extra++;
      end
      check("rst_no_late_write", extra, 0);

      // Resume from word 0, round 0
      run(1'b0, 0, -1, -1, dc, rd, wr, ex, ob, sb, lo, war);
      check("resume_done_cycle", dc, 301);
      check("resume_op_bad",     ob, 0);
      check("resume_seq_bad",    sb, 0);
      tick();

      // start held high: back-to-back runs with one IDLE cycle between
      run(1'b0, 1, 100000, -1, dc, rd, wr, ex, ob, sb, lo, war);
      check("b2b_done_cycle", dc, 301);
      tick();
      check("b2b_idle_busy",  busy,     0);
      check("b2b_idle_addr",  addr_sel, 2);
      tick();
      check("b2b_read_again", mem_rd,   1);
      check("b2b_busy_again", busy,     1);
      check("b2b_word_cnt",   word_cnt, 0);
      start = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("b2b_reset_idle", busy, 0);

`ifdef LANE_ROUND_CTRL_SKIP_EN
      // Even words skipped: 13 one-cycle words + 12 three-cycle words per round
      skip_mode = 1'b1;
      run(1'b0, 0, -1, -1, dc, rd, wr, ex, ob, sb, lo, war);
      skip_mode = 1'b0;
      skip_word = 1'b0;
      check("skip_done_cycle", dc, 197);
      check("skip_reads",      rd, 100);
      check("skip_writes",     wr, 48);
      check("skip_execs",      ex, 48);
      check("skip_op_bad",     ob, 0);
      check("skip_seq_bad",    sb, 0);
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/lane_round_ctrl.md
# lane_round_ctrl

Sequencing controller for the 25-word × 128-bit state memory datapath. On `start` it sweeps every word address for a configurable number of rounds. For each word it issues a memory read, selects one of four 128-bit operation results through the datapath's 4:1 select, latches the result, and writes it back. It drives the 5-bit address 3:1 select (read counter / write counter / host address) and the 2-bit operation select; it holds no data itself.

## Interface
- `NUM_WORDS`, 25, words per round; 2..32
- `ADDR_W`, 5, address/counter width; `NUM_WORDS` ≤ 2^`ADDR_W`
- `NUM_ROUNDS`, 4, rounds per run; 1..16
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  run request, sampled only in IDLE
- `op_mode`  in  1  0: op_sel = round index mod 4; 1: op_sel = 2'b11 for every round
- `word_cnt`  out  `ADDR_W`  current word index, drives address mux inputs A (read) and B (write)
- `addr_sel`  out  2  address mux select: 00 read counter, 01 write counter, 10 host address
- `op_sel`  out  2  operation mux select
- `mem_rd`  out  1  memory read strobe
- `ld_reg`  out  1  result register load enable
- `mem_wr`  out  1  memory write strobe
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle completion pulse
- `round_idx`  out  4  current round, 0-based

## Operation
- States: IDLE, READ, EXEC, WRITE, DONE.
- IDLE: `addr_sel` = 10 (host owns memory); all strobes 0; `start` = 1 → READ with `word_cnt` = 0 and `round_idx` = 0.
- READ: `mem_rd` = 1, `addr_sel` = 00 → EXEC.
- EXEC: `ld_reg` = 1, `op_sel` valid; `addr_sel` = 00 → WRITE.
- WRITE: `mem_wr` = 1, `addr_sel` = 01, `word_cnt` unchanged from READ.
  - If `word_cnt` < `NUM_WORDS`-1: `word_cnt`++ → READ.
  - Else, if `round_idx` < `NUM_ROUNDS`-1: `word_cnt` = 0, `round_idx`++ → READ.
  - Else → DONE.
- DONE: `done` = 1, `busy` = 0, `addr_sel` = 10 → IDLE; `word_cnt` and `round_idx` cleared on exit.
- `op_sel` = `op_mode` ? 2'b11 : `round_idx[1:0]`. It is held constant through READ/EXEC/WRITE of a word and is 00 in IDLE/DONE.
- `op_mode` is sampled on the `start` cycle and held for the whole run.
- `start` outside IDLE is ignored; no queuing. `start` held high continuously produces back-to-back runs separated by DONE and one IDLE cycle.
- `word_cnt` wraps only by explicit clear, never by overflow.

## Timing
- Reset: state IDLE; `word_cnt`, `round_idx`, `op_sel`, `mem_rd`, `ld_reg`, `mem_wr`, `busy`, `done` = 0; `addr_sel` = 10.
- All outputs are registered or decoded from state registers only; no combinational path from inputs.
- Memory read data is valid the cycle after READ, which is why the result is latched in EXEC. The write uses the result register value in WRITE.
- Per word: 3 cycles. Start accepted at cycle 0 gives first READ at cycle 1 and `done` at cycle 1 + 3·`NUM_WORDS`·`NUM_ROUNDS`. Default: cycle 301.
- `busy` = 1 exactly in READ, EXEC, WRITE.
- `rst` mid-run: next cycle is IDLE with reset values. Any in-flight strobe is dropped, and a write is never issued after reset.

## Configuration
- `LANE_ROUND_CTRL_SKIP_EN`: adds input `skip_word` (1 bit, sampled in READ).
  - When 1, EXEC and WRITE are suppressed for that word (no `ld_reg`, no `mem_wr`), and the counter advance of WRITE happens directly from READ.
  - Without the macro, no port exists and every word costs 3 cycles.

## Structure
- Shared package `lane_pkg`:
  - state enum `ctrl_state_t` {IDLE, READ, EXEC, WRITE, DONE}
  - `ADDR_SEL_RD`/`ADDR_SEL_WR`/`ADDR_SEL_HOST` (2'b00/01/10)
  - `OP_FIXED` = 2'b11
- One sub-module, `lane_word_counter`: `word_cnt`/`round_idx` pair with increment/clear and last-word/last-round flags.
- FSM and output decode stay in the top.

## Test plan
- Reset then idle 5 cycles → all strobes 0, `addr_sel` = 10, `busy` = 0.
- `start` for 1 cycle, defaults, `op_mode` = 0 → `done` at cycle 301; 100 `mem_wr` pulses. `op_sel` is 0,1,2,3 per round; word 24 of round 3 is written at cycle 300.
- `op_mode` = 1 run → `op_sel` = 11 on all 100 EXEC cycles.
- `start` pulsed during cycles 50–60 of a run → ignored, single `done` at cycle 301.
- `rst` asserted at cycle 150 (a WRITE cycle) → cycle 151 IDLE, `mem_wr` = 0, counters 0; a new `start` resumes from word 0, round 0.
- With `LANE_ROUND_CTRL_SKIP_EN`, `skip_word` = 1 on every even word → 13 skipped words per round; `done` at cycle 1 + 4·(13·1 + 12·3) = 197.
